ifid_latch: RTL and testbench

IF/ID pipeline register for the five-stage pipeline: captures the fetched instruction and its PC+4 and presents the decode-stage fields consumed by the hazard unit and the decoder. Acts on the hazard unit's load-use stall (`lw_nop`) and control-flow flushes (`jmp_flush`, `brch_flush`). Tracks a fetch that is still in flight when a flush is raised, and discards that wrong-path word when it returns.

---
 rtl/ifid_latch.sv | 131 +++++++++++++
 tb/tb_ifid_latch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_latch.sv
// IF/ID pipeline register with load-use stall, control-flow flush and wrong-path fetch squash.
// Optional statistics counters are enabled by defining IFID_STATS_EN.
module ifid_latch (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic [31:0] pc_plus4,
    input  logic        lw_nop,
    input  logic        jmp_flush,
    input  logic        brch_flush,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic [4:0]  ifid_rs_out,
    output logic [4:0]  ifid_rt_out,
    output logic        pc_en,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic {
        RUN         = 1'b0,
        SQUASH_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic        flush;

    assign flush = jmp_flush | brch_flush;

    always_comb begin
        state_d = RUN;
        if ((flush & ~ihit) | ((state_q == SQUASH_PEND) & ~ihit))
            state_d = SQUASH_PEND;

        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (lw_nop) begin
            instr_d = instr_q;
            npc_d   = npc_q;
            valid_d = valid_q;
        end else if ((state_q == SQUASH_PEND) & ihit) begin
            // Wrong-path word returning after a flush: drop it; PC still holds the redirect target.
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (ihit) begin
            instr_d = imemload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
        end else begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign ifid_instr  = instr_q;
    assign ifid_npc    = npc_q;
    assign ifid_valid  = valid_q;
    assign ifid_rs_out = instr_q[25:21];
    assign ifid_rt_out = instr_q[20:16];
    assign pc_en       = flush | (ihit & ~lw_nop & (state_q == RUN));

`ifdef IFID_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF))
            return v + 32'd1;
        return v;
    endfunction

    // A bubble is either a squashed wrong-path word or a cycle with no fetch return.
    assign bubble = ~flush & ~lw_nop & (((state_q == SQUASH_PEND) & ihit) | ~ihit);

    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, lw_nop & ~flush);
        flush_cnt_d  = sat_inc(flush_cnt_q, flush);
        bubble_cnt_d = sat_inc(bubble_cnt_q, bubble);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_latch.sv
// Directed testbench for ifid_latch: stall, flush, squash, reset-while-pending and back-to-back loads.
module tb_ifid_latch;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic [31:0] pc_plus4;
    logic        lw_nop;
    logic        jmp_flush;
    logic        brch_flush;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic [4:0]  ifid_rs_out;
    logic [4:0]  ifid_rt_out;
    logic        pc_en;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

`ifdef IFID_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    ifid_latch dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .imemload   (imemload),
        .pc_plus4   (pc_plus4),
        .lw_nop     (lw_nop),
        .jmp_flush  (jmp_flush),
        .brch_flush (brch_flush),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .ifid_valid (ifid_valid),
        .ifid_rs_out(ifid_rs_out),
        .ifid_rt_out(ifid_rt_out),
        .pc_en      (pc_en),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic hit, input logic [31:0] word, input logic [31:0] npc,
                         input logic stall, input logic jf, input logic bf);
        ihit       = hit;
        imemload   = word;
        pc_plus4   = npc;
        lw_nop     = stall;
        jmp_flush  = jf;
        brch_flush = bf;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: instr=%h npc=%h valid=%b required 0/0/0", ifid_instr, ifid_npc, ifid_valid);
        end
        checks++;
        if (ifid_rs_out !== 5'd0 || ifid_rt_out !== 5'd0 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_fields: rs=%0d rt=%0d pc_en=%b required 0/0/0", ifid_rs_out, ifid_rt_out, pc_en);
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: %0d %0d %0d required 0 0 0", stall_cnt, flush_cnt, bubble_cnt);
        end
    endtask

    task automatic test_load();
        nRST = 1'b1;
        drive(1'b1, 32'h8C22_0004, 32'h4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL load_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h8C22_0004 || ifid_npc !== 32'h4 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_regs: instr=%h npc=%h valid=%b required 8c220004/4/1", ifid_instr, ifid_npc, ifid_valid);
        end
        checks++;
        if (ifid_rs_out !== 5'd1 || ifid_rt_out !== 5'd2) begin
            errors++;
            $display("FAIL load_fields: rs=%0d rt=%0d required 1/2", ifid_rs_out, ifid_rt_out);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h0043_2020, 32'h8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pc_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_pc_en[%0d]: got %b required 0", i, pc_en);
            end
            step();
            checks++;
            if (ifid_instr !== 32'h8C22_0004 || ifid_npc !== 32'h4 || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: instr=%h npc=%h valid=%b required 8c220004/4/1", i, ifid_instr, ifid_npc, ifid_valid);
            end
        end
        drive(1'b1, 32'h0043_2020, 32'h8, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h0043_2020 || ifid_npc !== 32'h8 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_load: instr=%h npc=%h valid=%b required 00432020/8/1", ifid_instr, ifid_npc, ifid_valid);
        end
        checks++;
        if (stall_cnt !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, STATS ? 2 : 0);
        end
    endtask

    task automatic test_branch_flush();
        drive(1'b1, 32'h1111_1111, 32'hC, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL brch_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL brch_clear: instr=%h npc=%h valid=%b required 0/0/0", ifid_instr, ifid_npc, ifid_valid);
        end
        drive(1'b1, 32'h012A_4020, 32'h10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL brch_state_run: pc_en=%b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h012A_4020 || ifid_rs_out !== 5'd9 || ifid_rt_out !== 5'd10 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL brch_after_load: instr=%h rs=%0d rt=%0d valid=%b required 012a4020/9/10/1", ifid_instr, ifid_rs_out, ifid_rt_out, ifid_valid);
        end
        checks++;
        if (flush_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL brch_flush_cnt: got %0d required %0d", flush_cnt, STATS ? 1 : 0);
        end
    endtask

    task automatic test_squash();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL squash_flush_pc_en: got %b required 1", pc_en);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 32'hDEAD_BEEF, 32'h18, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b0) begin
            errors++;
            $display("FAIL squash_discard_pc_en: got %b required 0", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_discard: instr=%h valid=%b required 0/0", ifid_instr, ifid_valid);
        end
        drive(1'b1, 32'h0128_5020, 32'h20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL squash_exit_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h0128_5020 || ifid_npc !== 32'h20 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL squash_next_load: instr=%h npc=%h valid=%b required 01285020/20/1", ifid_instr, ifid_npc, ifid_valid);
        end
        checks++;
        if (flush_cnt !== (STATS ? 32'd2 : 32'd0) || bubble_cnt !== (STATS ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL squash_counters: flush=%0d bubble=%0d required %0d/%0d", flush_cnt, bubble_cnt, STATS ? 2 : 0, STATS ? 3 : 0);
        end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 32'h2222_2222, 32'h24, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_clear: instr=%h npc=%h valid=%b required 0/0/0", ifid_instr, ifid_npc, ifid_valid);
        end
        checks++;
        if (flush_cnt !== (STATS ? 32'd3 : 32'd0) || stall_cnt !== (STATS ? 32'd2 : 32'd0)) begin
            errors++;
            $display("FAIL flush_stall_counters: flush=%0d stall=%0d required %0d/%0d", flush_cnt, stall_cnt, STATS ? 3 : 0, STATS ? 2 : 0);
        end
    endtask

    task automatic test_reset_pending();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hAC43_0008, 32'h30, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_en !== 1'b0) begin
            errors++;
            $display("FAIL pend_before_reset_pc_en: got %b required 0", pc_en);
        end
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        #1;
        checks++;
        if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0 || ifid_valid !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL pend_reset_clear: instr=%h npc=%h valid=%b cnt=%0d/%0d/%0d required all 0", ifid_instr, ifid_npc, ifid_valid, stall_cnt, flush_cnt, bubble_cnt);
        end
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL pend_reset_pc_en: got %b required 1", pc_en);
        end
        step();
        checks++;
        if (ifid_instr !== 32'hAC43_0008 || ifid_npc !== 32'h30 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL pend_reset_latch: instr=%h npc=%h valid=%b required ac430008/30/1", ifid_instr, ifid_npc, ifid_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h03E0_0008;
        words[1] = 32'h8FBF_0010;
        words[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, words[i], 32'h40 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            step();
            checks++;
            if (ifid_instr !== words[i] || ifid_npc !== 32'h40 + 32'(4 * i) || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: instr=%h npc=%h valid=%b required %h/%h/1", i, ifid_instr, ifid_npc, ifid_valid, words[i], 32'h40 + 32'(4 * i));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || ifid_npc !== 32'h0) begin
            errors++;
            $display("FAIL b2b_bubble: instr=%h npc=%h valid=%b required 0/0/0", ifid_instr, ifid_npc, ifid_valid);
        end
    endtask

    initial begin
        nRST       = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        pc_plus4   = '0;
        lw_nop     = 1'b0;
        jmp_flush  = 1'b0;
        brch_flush = 1'b0;
        test_reset();
        test_load();
        test_stall();
        test_branch_flush();
        test_squash();
        test_flush_stall();
        test_reset_pending();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
